// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Multi-cycle RV32I load/store unit. It accepts one access from
//            the MEMORY stage and runs a single req/ack data-bus transaction.
//            It returns an aligned, sign/zero-extended load result for
//            write-back, and reports misalignment, illegal funct3 and bus
//            timeout.
// Ports    : clk_i, rst_ni            - clock, async active-low reset
//            start_i, is_load_i,      - access request and its operands
//            is_store_i, funct3_i,
//            addr_i, store_data_i
//            mem_req_o .. mem_be_o    - registered data-bus request
//            mem_rdata_i, mem_ack_i   - data-bus response
//            load_result_o            - extended load value (held)
//            done_o, err_code_o       - completion pulse and status
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic [31:0] load_result_o,
  output logic        done_o,
  output logic [1:0]  err_code_o
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FUNCT3   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;       // captured byte offset for load extraction
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;

  // Shift the addressed byte/halfword to bit 0, then extend per funct3.
  function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b100:  res = {24'h0, sh[7:0]};
      3'b101:  res = {16'h0, sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  logic       load_sel;
  logic       store_sel;
  logic       illegal_f3;
  logic       misaligned;
  logic [7:0] cnt_inc;

  always_comb begin
    // is_load_i takes priority when both type bits are set.
    load_sel  = is_load_i;
    store_sel = is_store_i & ~is_load_i;

    illegal_f3 = 1'b0;
    if (load_sel) begin
      illegal_f3 = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (store_sel) begin
      illegal_f3 = !(funct3_i inside {3'b000, 3'b001, 3'b010});
    end

    misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

    cnt_inc = cnt_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    off_d     = off_q;
    funct3_d  = funct3_q;
    is_load_d = is_load_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    result_d  = result_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          off_d     = addr_i[1:0];
          funct3_d  = funct3_i;
          is_load_d = load_sel;
          err_d     = ERR_NONE;
          if (illegal_f3) begin
            err_d   = ERR_FUNCT3;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if ((load_sel || store_sel) && misaligned) begin
            err_d   = ERR_MISALIGN;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (!(load_sel || store_sel)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = store_sel;
            addr_d  = {addr_i[31:2], 2'b00};
            cnt_d   = 8'd0;
            state_d = S_REQ;
            if (load_sel) begin
              be_d = 4'b1111;
            end else begin
              case (funct3_i[1:0])
                2'b00: begin
                  wdata_d = {4{store_data_i[7:0]}};
                  be_d    = 4'b0001 << addr_i[1:0];
                end
                2'b01: begin
                  wdata_d = {2{store_data_i[15:0]}};
                  be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                  wdata_d = store_data_i;
                  be_d    = 4'b1111;
                end
              endcase
            end
          end
        end
      end

      S_REQ: begin
        cnt_d = cnt_inc;
        // An ack in the timeout cycle is still a successful access.
        if (mem_ack_i) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = ERR_NONE;
          state_d = S_DONE;
          if (is_load_q) begin
            result_d = extract_load(mem_rdata_i, off_q, funct3_q);
          end
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = ERR_TIMEOUT;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      off_q     <= 2'b00;
      funct3_q  <= 3'b000;
      is_load_q <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'h0;
      result_q  <= 32'h0;
      done_q    <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      off_q     <= off_d;
      funct3_q  <= funct3_d;
      is_load_q <= is_load_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      result_q  <= result_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_be_o      = be_q;
  assign load_result_o = result_q;
  assign done_o        = done_q;
  assign err_code_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Directed self-checking bench for lsu. Instance u_dut uses the
//            default timeout; u_dut_to uses TIMEOUT_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

  logic        clk;
  logic        rst_n;
  logic        start, start_t;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata, rdata;
  logic        ack, ack_t;

  logic        req, we, done;
  logic [31:0] maddr, wdata, result;
  logic [3:0]  be;
  logic [1:0]  err;

  logic        req_t, we_t, done_t;
  logic [31:0] maddr_t, wdata_t, result_t;
  logic [3:0]  be_t;
  logic [1:0]  err_t;

  int checks;
  int errors;

  lsu u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .is_load_i(is_load), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .store_data_i(sdata),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr),
    .mem_wdata_o(wdata), .mem_be_o(be),
    .mem_rdata_i(rdata), .mem_ack_i(ack),
    .load_result_o(result), .done_o(done), .err_code_o(err)
  );

  lsu #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_t),
    .is_load_i(is_load), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .store_data_i(sdata),
    .mem_req_o(req_t), .mem_we_o(we_t), .mem_addr_o(maddr_t),
    .mem_wdata_o(wdata_t), .mem_be_o(be_t),
    .mem_rdata_i(rdata), .mem_ack_i(ack_t),
    .load_result_o(result_t), .done_o(done_t), .err_code_o(err_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    sdata    = d;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  int req_cnt;
  int early_done;
  int seen_done;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; start_t = 1'b0; ack = 1'b0; ack_t = 1'b0;
    is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; sdata = 32'h0; rdata = 32'h0;
    tick(); tick();
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_err", {30'h0, err}, 32'h0);
    check("rst_be", {28'h0, be}, 32'h0);

    // LB at 0x1003, zero-wait
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0);
    check("lb_req", {31'h0, req}, 32'h1);
    check("lb_addr", maddr, 32'h0000_1000);
    check("lb_be", {28'h0, be}, 32'hF);
    check("lb_we", {31'h0, we}, 32'h0);
    ack = 1'b1; rdata = 32'h80FF_0011;
    tick();
    ack = 1'b0;
    check("lb_done", {31'h0, done}, 32'h1);
    check("lb_req_drop", {31'h0, req}, 32'h0);
    check("lb_result", result, 32'hFFFF_FF80);
    check("lb_err", {30'h0, err}, 32'h0);
    tick();
    check("lb_done_pulse", {31'h0, done}, 32'h0);

    // LHU at 0x2002, ack after 5 wait cycles
    issue(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0);
    req_cnt = 0; early_done = 0;
    rdata = 32'h8001_7F7F;
    for (int i = 0; i < 6; i++) begin
      if (req) req_cnt++;
      if (done) early_done++;
      ack = (i == 5);
      tick();
    end
    ack = 1'b0;
    check("lhu_req_cycles", req_cnt, 32'd6);
    check("lhu_no_early_done", early_done, 32'd0);
    check("lhu_done", {31'h0, done}, 32'h1);
    check("lhu_result", result, 32'h0000_8001);
    tick();

    // SB at 0x0001
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0001, 32'h1234_56AB);
    check("sb_wdata", wdata, 32'hABAB_ABAB);
    check("sb_be", {28'h0, be}, 32'h2);
    check("sb_we", {31'h0, we}, 32'h1);
    check("sb_addr", maddr, 32'h0000_0000);
    ack = 1'b1; tick(); ack = 1'b0;
    check("sb_done", {31'h0, done}, 32'h1);
    check("sb_result_kept", result, 32'h0000_8001);
    tick();

    // SH at 0x0002
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h0000_BEEF);
    check("sh_wdata", wdata, 32'hBEEF_BEEF);
    check("sh_be", {28'h0, be}, 32'hC);
    ack = 1'b1; tick(); ack = 1'b0;
    check("sh_done", {31'h0, done}, 32'h1);
    check("sh_result_kept", result, 32'h0000_8001);
    tick();

    // Error paths
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0);
    check("lw_mis_req", {31'h0, req}, 32'h0);
    check("lw_mis_done", {31'h0, done}, 32'h1);
    check("lw_mis_err", {30'h0, err}, 32'h1);
    tick();
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0);
    check("sh_mis_req", {31'h0, req}, 32'h0);
    check("sh_mis_done", {31'h0, done}, 32'h1);
    check("sh_mis_err", {30'h0, err}, 32'h1);
    tick();
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0);
    check("ld_f3_req", {31'h0, req}, 32'h0);
    check("ld_f3_done", {31'h0, done}, 32'h1);
    check("ld_f3_err", {30'h0, err}, 32'h2);
    check("err_result_kept", result, 32'h0000_8001);
    tick();

    // Timeout instance: successful LW to give a prior result
    is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0040;
    start_t = 1'b1; tick(); start_t = 1'b0;
    ack_t = 1'b1; rdata = 32'hCAFE_F00D; tick(); ack_t = 1'b0;
    check("to_prior_done", {31'h0, done_t}, 32'h1);
    check("to_prior_result", result_t, 32'hCAFE_F00D);
    tick();

    // LW with no ack: times out after 4 request cycles
    start_t = 1'b1; tick(); start_t = 1'b0;
    req_cnt = 0; seen_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (done_t) begin
        seen_done = 1;
        break;
      end
      if (req_t) req_cnt++;
      tick();
    end
    check("to_seen_done", seen_done, 32'd1);
    check("to_req_cycles", req_cnt, 32'd4);
    check("to_err", {30'h0, err_t}, 32'h3);
    check("to_result_kept", result_t, 32'hCAFE_F00D);
    tick();

    // Ack in the same cycle as the timeout wins
    start_t = 1'b1; tick(); start_t = 1'b0;
    rdata = 32'h1122_3344;
    tick(); tick(); tick();
    check("to_race_req", {31'h0, req_t}, 32'h1);
    ack_t = 1'b1; tick(); ack_t = 1'b0;
    check("to_race_done", {31'h0, done_t}, 32'h1);
    check("to_race_err", {30'h0, err_t}, 32'h0);
    check("to_race_result", result_t, 32'h1122_3344);
    tick();

    // Reset mid-REQ
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    check("rq_req", {31'h0, req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rq_req_async", {31'h0, req}, 32'h0);
    check("rq_addr", maddr, 32'h0);
    check("rq_wdata", wdata, 32'h0);
    check("rq_result", result, 32'h0);
    check("rq_err", {30'h0, err}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    ack = 1'b1; tick(); ack = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      if (done) seen_done++;
      tick();
    end
    check("rq_late_ack_no_done", seen_done, 32'd0);

    // Extra start pulses while busy are ignored
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
    is_load = 1'b0; is_store = 1'b1; addr = 32'h0000_0300; sdata = 32'h5555_5555;
    start = 1'b1; tick(); start = 1'b0;
    check("busy_addr", maddr, 32'h0000_0200);
    check("busy_we", {31'h0, we}, 32'h0);
    ack = 1'b1; rdata = 32'hA5A5_A5A5; tick(); ack = 1'b0;
    check("busy_done", {31'h0, done}, 32'h1);
    start = 1'b1; tick(); start = 1'b0;
    seen_done = 0; req_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done++;
      if (req) req_cnt++;
      tick();
    end
    check("busy_one_done", seen_done, 32'd0);
    check("busy_no_req", req_cnt, 32'd0);
    check("busy_result", result, 32'hA5A5_A5A5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
